ps2_keyevent: RTL
=================

Name: ps2_keyevent

Overview:
- Consumes the byte stream from the PS/2 frame decoder (scan_ready / 8-bit scan_code, generated in the PS/2 clock domain) and produces one key event per make or break.
- Resynchronises the decoder's ready strobe into the system clock and folds the E0 (extended), F0 (break) and E1 (pause) prefixes into a single event.
- Tracks shift state and buffers events in a small FIFO with a valid/ready handshake toward the character or terminal logic.

Parameters:
- SYNC_STAGES, 2, flops in the scan_ready synchroniser chain; must be ≥ 2.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- i_clock  input  1  system clock, ≥ 1 MHz; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- i_scan_ready  input  1  decoder byte-valid level, asynchronous to i_clock, high for ≥ 30 us per byte.
- i_scan_code  input  8  decoder byte; stable while i_scan_ready is high.
- o_valid  output  1  FIFO non-empty; head event is presented.
- i_ready  input  1  consumer accepts the head event when o_valid & i_ready.
- o_key  output  8  head event key code; E1 = pause.
- o_break  output  1  head event is a release (1) or a press (0).
- o_extended  output  1  head event was E0-prefixed.
- o_shift  output  1  shift state after the head event was applied.
- o_shift_now  output  1  live shift state: lshift | rshift.
- o_overflow  output  1  sticky; an event was dropped because the FIFO was full.
- o_level  output  FIFO_AW+1  FIFO occupancy.

Behaviour:
- Reset values: o_valid, o_key, o_break, o_extended, o_shift, o_shift_now, o_overflow and o_level are all 0. The synchroniser, FSM, skip counter, shift flags and FIFO pointers are also cleared. Reset mid-sequence discards any partial prefix and all buffered events.
- Sync and strobe:
  - i_scan_ready passes through SYNC_STAGES flops plus one history flop.
  - strobe = last sync flop & ~history flop; exactly one strobe per high period of i_scan_ready.
  - i_scan_code is sampled directly on the strobe cycle; no synchroniser is needed because it is stable.
- Latency: let t0 be the first edge that samples i_scan_ready high. The byte is consumed and any event is written at edge t0+SYNC_STAGES. o_valid rises after that edge if the FIFO was empty.
- FSM (advances only on strobe):
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - E1 → SKIP with skip_cnt = 7.
    - 00, AA, EE, FA, FC, FE, FF → dropped, stay IDLE.
    - Any other byte → emit {code, break=0, ext=0}.
  - EXT:
    - F0 → EXTBRK.
    - E0 → stay EXT.
    - Any other byte → emit {code, 0, 1}, → IDLE.
  - BRK: any byte → emit {code, 1, 0}, → IDLE.
  - EXTBRK: any byte → emit {code, 1, 1}, → IDLE.
  - SKIP:
    - Each byte decrements skip_cnt.
    - The byte that takes skip_cnt to 0 emits {E1, 0, 0} and → IDLE.
    - The full pause sequence E1 14 77 E1 F0 14 F0 77 therefore yields exactly one event.
- Shift tracking:
  - Non-extended 12 sets lshift on make and clears it on break; 59 does the same for rshift.
  - Extended 12 and 59 (print-screen fakes) do not affect shift.
  - The flag updates at the same edge the event is written. The stored o_shift reflects the post-update value.
  - Shift updates even if the event is dropped.
- FIFO:
  - Entry = {key[7:0], break, extended, shift}, 11 bits.
  - Push on emit; pop on o_valid & i_ready.
  - Push when full with no simultaneous pop: the event is dropped and o_overflow is set (cleared only by reset).
  - Push and pop in the same cycle while full: both occur, level unchanged, no overflow.
  - Push and pop in the same cycle while empty: not possible, because o_valid is 0.
  - Pointers wrap modulo 2**FIFO_AW. Full is detected with an extra MSB.
  - Head outputs are registered or read combinationally from the head entry. Outputs are held stable while o_valid & ~i_ready.
- Each byte produces at most one event. Consecutive bytes are ≥ 10 PS/2 bit times apart, so no strobe overlap can occur.

Test Plan:
- Bytes 1C, then F0 1C, i_ready=1 → two events {1C,0,0,0} then {1C,1,0,0}. o_valid rises exactly SYNC_STAGES edges after the first high sample.
- E0 75, then E0 F0 75 → {75,0,1,0} and {75,1,1,0}. Bytes AA and FA produce no event.
- 12 (lshift make), 1C, F0 12, 1C → events with shift bits 1, 1, 0, 0. o_shift_now tracks the same values. E0 12 leaves shift unchanged.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,0,0,0}. A following 1C emits normally.
- i_ready=0, send 5 make codes with FIFO_AW=2 → o_level=4, o_overflow=1, the fifth code is lost. Drain with i_ready=1 → the first four codes appear in order, then o_valid=0.
- Send E0 F0, assert reset for one cycle, then send 1C → one event {1C,0,0,0}. FIFO empty and o_overflow=0 immediately after reset.

Source files
------------

// File: rtl/ps2_keyevent.sv
// ps2_keyevent: folds PS/2 scan-code prefixes into key events and queues them in a small FIFO.
// Rev 1.0 - initial release.
`default_nettype none

module ps2_keyevent #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_AW     = 2
) (
  input  logic               i_clock,
  input  logic               reset,
  input  logic               i_scan_ready,
  input  logic [7:0]         i_scan_code,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [7:0]         o_key,
  output logic               o_break,
  output logic               o_extended,
  output logic               o_shift,
  output logic               o_shift_now,
  output logic               o_overflow,
  output logic [FIFO_AW:0]   o_level
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXT    = 3'd1,
    S_BRK    = 3'd2,
    S_EXTBRK = 3'd3,
    S_SKIP   = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_strobe;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_skip, w_skip_nxt;
  logic       w_emit;
  logic [7:0] w_key;
  logic       w_brk;
  logic       w_ext;

  logic r_lshift, r_rshift;
  logic w_lshift_nxt, w_rshift_nxt, w_shift_nxt;

  logic [10:0]      r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr, r_rptr;
  logic             r_overflow;
  logic             w_empty, w_full, w_pop, w_push;
  logic [10:0]      w_head;

  // scan_code needs no synchroniser: it is stable for the whole ready-high window.
  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_scan_ready};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_strobe = r_sync[SYNC_STAGES-1] & ~r_hist;

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_skip  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_emit      = 1'b0;
    w_key       = i_scan_code;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (w_strobe) begin
      case (r_state)
        S_IDLE: begin
          case (i_scan_code)
            8'hE0: w_state_nxt = S_EXT;
            8'hF0: w_state_nxt = S_BRK;
            8'hE1: begin
              w_state_nxt = S_SKIP;
              w_skip_nxt  = 3'd7;
            end
            // Keyboard status/acknowledge bytes, not key codes.
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: w_state_nxt = S_IDLE;
            default: w_emit = 1'b1;
          endcase
        end
        S_EXT: begin
          case (i_scan_code)
            8'hF0: w_state_nxt = S_EXTBRK;
            8'hE0: w_state_nxt = S_EXT;
            default: begin
              w_emit      = 1'b1;
              w_ext       = 1'b1;
              w_state_nxt = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          w_emit      = 1'b1;
          w_brk       = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_EXTBRK: begin
          w_emit      = 1'b1;
          w_brk       = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_SKIP: begin
          w_skip_nxt = r_skip - 3'd1;
          if (r_skip == 3'd1) begin
            w_emit      = 1'b1;
            w_key       = 8'hE1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Extended 12/59 are print-screen fakes and must not disturb shift.
  always_comb begin
    w_lshift_nxt = r_lshift;
    w_rshift_nxt = r_rshift;
    if (w_emit && !w_ext && (w_key == 8'h12)) w_lshift_nxt = ~w_brk;
    if (w_emit && !w_ext && (w_key == 8'h59)) w_rshift_nxt = ~w_brk;
  end

  assign w_shift_nxt = w_lshift_nxt | w_rshift_nxt;

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
    end else begin
      r_lshift <= w_lshift_nxt;
      r_rshift <= w_rshift_nxt;
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_pop   = ~w_empty & i_ready;
  assign w_push  = w_emit & (~w_full | w_pop);

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_emit && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= {w_key, w_brk, w_ext, w_shift_nxt};
  end

  // Gate the head with valid so stale memory never shows on the outputs.
  assign w_head      = w_empty ? 11'd0 : r_mem[r_rptr[FIFO_AW-1:0]];
  assign o_valid     = ~w_empty;
  assign o_key       = w_head[10:3];
  assign o_break     = w_head[2];
  assign o_extended  = w_head[1];
  assign o_shift     = w_head[0];
  assign o_shift_now = r_lshift | r_rshift;
  assign o_overflow  = r_overflow;
  assign o_level     = r_wptr - r_rptr;

endmodule

`default_nettype wire
